// File: rtl/linecoding_enc_nlane.sv
// N-lane IEEE 802.3 Clause 36 8b/10b encoder behind a single output register slice.
// Each lane keeps its own running disparity; optional K28.5 idle fill when no input is offered.
module linecoding_enc_nlane #(
  parameter int LANES   = 2,
  parameter int IDLE_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*LANES-1:0]  in_data,
  input  logic [LANES-1:0]    in_k,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [10*LANES-1:0] out_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_idle,
  output logic [LANES-1:0]    rd,
  output logic [LANES-1:0]    err_k
);

  localparam logic [7:0] K28_5 = 8'hBC;

  // 5b/6b RD- column, abcdei with 'a' in the MSB
  function automatic logic [5:0] code6_neg(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:    c = 6'b100111;
      5'd1:    c = 6'b011101;
      5'd2:    c = 6'b101101;
      5'd3:    c = 6'b110001;
      5'd4:    c = 6'b110101;
      5'd5:    c = 6'b101001;
      5'd6:    c = 6'b011001;
      5'd7:    c = 6'b111000;
      5'd8:    c = 6'b111001;
      5'd9:    c = 6'b100101;
      5'd10:   c = 6'b010101;
      5'd11:   c = 6'b110100;
      5'd12:   c = 6'b001101;
      5'd13:   c = 6'b101100;
      5'd14:   c = 6'b011100;
      5'd15:   c = 6'b010111;
      5'd16:   c = 6'b011011;
      5'd17:   c = 6'b100011;
      5'd18:   c = 6'b010011;
      5'd19:   c = 6'b110010;
      5'd20:   c = 6'b001011;
      5'd21:   c = 6'b101010;
      5'd22:   c = 6'b011010;
      5'd23:   c = 6'b111010;
      5'd24:   c = 6'b110011;
      5'd25:   c = 6'b100110;
      5'd26:   c = 6'b010110;
      5'd27:   c = 6'b110110;
      5'd28:   c = 6'b001110;
      5'd29:   c = 6'b101110;
      5'd30:   c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b RD- column for data; y=7 is the primary P7 form
  function automatic logic [3:0] code4_data_neg(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b1001;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b0110;
      default: c = 4'b1110;
    endcase
    return c;
  endfunction

  // 3b/4b RD- column for control characters; every entry inverts at RD+
  function automatic logic [3:0] code4_k_neg(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b0110;
      3'd2:    c = 4'b1010;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b0101;
      3'd6:    c = 4'b1001;
      default: c = 4'b0111;
    endcase
    return c;
  endfunction

  // Returns {illegal_k, rd_after, abcdei, fghj}
  function automatic logic [11:0] encode_lane(input logic [7:0] d, input logic k, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic       legal;
    logic       bad;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       flip6;
    logic       flip4;
    logic       rd_mid;
    logic       rd_out;
    logic       use_a7;
    x      = d[4:0];
    y      = d[7:5];
    legal  = (x == 5'd28) ||
             ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
    bad    = k && !legal;
    use_a7 = 1'b0;
    if (bad) begin
      x = K28_5[4:0];
      y = K28_5[7:5];
    end
    if (k && (x == 5'd28)) c6 = 6'b001110 | 6'b000001;
    else                   c6 = code6_neg(x);
    // D.7 is balanced but still alternates between its two columns
    flip6 = ($countones(c6) != 3) || (!k && (x == 5'd7));
    if (rd_in && flip6) c6 = ~c6;
    rd_mid = ($countones(c6) == 3) ? rd_in : ($countones(c6) > 3);
    if (k) begin
      c4    = code4_k_neg(y);
      flip4 = 1'b1;
    end else if (y == 3'd7) begin
      use_a7 = rd_mid ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                      : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20));
      c4     = use_a7 ? 4'b0111 : 4'b1110;
      flip4  = 1'b1;
    end else begin
      c4    = code4_data_neg(y);
      flip4 = ($countones(c4) != 2) || (y == 3'd3);
    end
    if (rd_mid && flip4) c4 = ~c4;
    rd_out = ($countones(c4) == 2) ? rd_mid : ($countones(c4) > 2);
    return {bad, rd_out, c6, c4};
  endfunction

  logic                load;
  logic [10*LANES-1:0] nxt_code;
  logic [LANES-1:0]    nxt_rd;
  logic [LANES-1:0]    nxt_err;

  assign load     = ~out_valid | out_ready;
  assign in_ready = load & ~rst;

  // Real data wins over idle fill; each lane encodes from its own disparity
  always_comb begin : encode_lanes
    logic [11:0] lane_word;
    lane_word = '0;
    nxt_code  = '0;
    nxt_rd    = rd;
    nxt_err   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (in_valid) lane_word = encode_lane(in_data[8*i +: 8], in_k[i], rd[i]);
      else          lane_word = encode_lane(K28_5, 1'b1, rd[i]);
      nxt_code[10*i +: 10] = lane_word[9:0];
      nxt_rd[i]            = lane_word[10];
      nxt_err[i]           = lane_word[11];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idle  <= 1'b0;
      out_code  <= '0;
      rd        <= '0;
      err_k     <= '0;
    end else if (load) begin
      if (in_valid || (IDLE_EN != 0)) begin
        out_valid <= 1'b1;
        out_idle  <= ~in_valid;
        out_code  <= nxt_code;
        rd        <= nxt_rd;
        err_k     <= in_valid ? nxt_err : '0;
      end else begin
        // Nothing is loaded, so disparity and the stale code stay put
        out_valid <= 1'b0;
        out_idle  <= 1'b0;
        err_k     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_linecoding_enc_nlane.sv
// Self-checking bench: two-lane and one-lane encoders without idle fill, two-lane with idle fill,
// compared against a column-table 8b/10b reference model.
module tb_linecoding_enc_nlane;

  localparam logic [5:0] T6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [7:0] LEGAL_K [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                          8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  localparam logic [9:0] K285N = 10'b0011111010;
  localparam logic [9:0] K285P = 10'b1100000101;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_k;
  logic        in_valid, out_ready;
  logic [15:0] b_in_data;
  logic [1:0]  b_in_k;
  logic        b_in_valid, b_out_ready;

  logic        a_in_ready, a_out_valid, a_out_idle;
  logic [19:0] a_out_code;
  logic [1:0]  a_rd, a_err_k;
  logic        c_in_ready, c_out_valid, c_out_idle;
  logic [9:0]  c_out_code;
  logic [0:0]  c_rd, c_err_k;
  logic        b_in_ready, b_out_valid, b_out_idle;
  logic [19:0] b_out_code;
  logic [1:0]  b_rd, b_err_k;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  linecoding_enc_nlane #(.LANES(2), .IDLE_EN(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_k(in_k), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_code(a_out_code), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_idle(a_out_idle), .rd(a_rd), .err_k(a_err_k));

  linecoding_enc_nlane #(.LANES(1), .IDLE_EN(0)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data[7:0]), .in_k(in_k[0:0]), .in_valid(in_valid),
    .in_ready(c_in_ready), .out_code(c_out_code), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_idle(c_out_idle), .rd(c_rd), .err_k(c_err_k));

  linecoding_enc_nlane #(.LANES(2), .IDLE_EN(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_k(b_in_k), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_code(b_out_code), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_idle(b_out_idle), .rd(b_rd), .err_k(b_err_k));

  // Reference: pick the column for the current disparity, then update disparity from the ones count
  function automatic logic [11:0] ref_enc(input logic [7:0] d_in, input logic k, input logic rd_in);
    logic [7:0] d;
    logic [4:0] x;
    logic [2:0] y;
    logic       r;
    logic       err;
    logic [5:0] c6;
    logic [3:0] c4;
    err = k && !((d_in[4:0] == 5'd28) || (d_in == 8'hF7) || (d_in == 8'hFB) ||
                 (d_in == 8'hFD) || (d_in == 8'hFE));
    d = err ? 8'hBC : d_in;
    x = d[4:0];
    y = d[7:5];
    r = rd_in;
    if (k && x == 5'd28) c6 = r ? 6'b110000 : 6'b001111;
    else                 c6 = r ? T6P[x] : T6N[x];
    if ($countones(c6) != 3) r = ($countones(c6) > 3);
    if (k) c4 = r ? K4P[y] : K4N[y];
    else if (y == 3'd7 && (r ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                             : (x == 5'd17 || x == 5'd18 || x == 5'd20)))
      c4 = r ? 4'b1000 : 4'b0111;
    else c4 = r ? T4P[y] : T4N[y];
    if ($countones(c4) != 2) r = ($countones(c4) > 2);
    return {err, r, c6, c4};
  endfunction

  // {err[1:0], rd[1:0], code[19:0]} for a two-lane beat
  function automatic logic [23:0] ref_beat(input logic [15:0] d, input logic [1:0] k, input logic [1:0] rd_in);
    logic [11:0] l0, l1;
    l0 = ref_enc(d[7:0], k[0], rd_in[0]);
    l1 = ref_enc(d[15:8], k[1], rd_in[1]);
    return {l1[11], l0[11], l1[10], l0[10], l1[9:0], l0[9:0]};
  endfunction

  task automatic rand_beat(output logic [15:0] d, output logic [1:0] k);
    logic [7:0] b;
    logic [3:0] idx;
    d = '0;
    k = '0;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        k[i] = 1'b1;
        idx  = 4'($urandom_range(0, 11));
        if ($urandom_range(0, 1) == 0) b = LEGAL_K[idx];
      end
      d[8*i +: 8] = b;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_k = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_k = '0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1; in_data = 16'hB5B5; in_k = '0; out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 16'hB5B5; b_in_k = '0; b_out_ready = 1'b1;
    #2;
    for (int pass = 0; pass < 2; pass++) begin
      n_cmp++;
      if (a_out_valid !== 1'b0 || a_out_idle !== 1'b0 || a_out_code !== 20'd0 || a_rd !== 2'b00 ||
          a_err_k !== 2'b00 || a_in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_a: got v=%b idle=%b code=%h rd=%b err=%b rdy=%b, want all 0",
                 a_out_valid, a_out_idle, a_out_code, a_rd, a_err_k, a_in_ready);
      end
      n_cmp++;
      if (b_out_valid !== 1'b0 || b_out_idle !== 1'b0 || b_out_code !== 20'd0 || b_rd !== 2'b00 ||
          b_err_k !== 2'b00 || b_in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_b: got v=%b idle=%b code=%h rd=%b err=%b rdy=%b, want all 0",
                 b_out_valid, b_out_idle, b_out_code, b_rd, b_err_k, b_in_ready);
      end
      n_cmp++;
      if (c_out_valid !== 1'b0 || c_out_code !== 10'd0 || c_rd !== 1'b0 || c_in_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_c: got v=%b code=%h rd=%b rdy=%b, want all 0",
                 c_out_valid, c_out_code, c_rd, c_in_ready);
      end
      repeat (2) @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_directed();
    logic [7:0] sd [4];
    logic       sk [4];
    logic [9:0] sc [4];
    logic       sr [4];
    sd = '{8'hB5, 8'h00, 8'hBC, 8'hBC};
    sk = '{1'b0, 1'b0, 1'b1, 1'b1};
    sc = '{10'b1010101010, 10'b1001110100, 10'b0011111010, 10'b1100000101};
    sr = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    n_cmp++;
    if (a_out_valid !== 1'b0 || c_out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL directed_idle_before: got v=%b/%b, want 0/0", a_out_valid, c_out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = {sd[i], sd[i]}; in_k = {sk[i], sk[i]}; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (a_out_valid !== 1'b1 || a_out_code !== {sc[i], sc[i]} || a_rd !== {sr[i], sr[i]}) begin
        n_fail++;
        $display("[TB] FAIL directed_a beat %0d: got v=%b code=%b rd=%b, want v=1 code=%b rd=%b",
                 i, a_out_valid, a_out_code, a_rd, {sc[i], sc[i]}, {sr[i], sr[i]});
      end
      n_cmp++;
      if (c_out_valid !== 1'b1 || c_out_code !== sc[i] || c_rd !== sr[i]) begin
        n_fail++;
        $display("[TB] FAIL directed_c beat %0d: got v=%b code=%b rd=%b, want v=1 code=%b rd=%b",
                 i, c_out_valid, c_out_code, c_rd, sc[i], sr[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_illegal_k();
    do_reset();
    in_valid = 1'b1; in_data = 16'h00B5; in_k = 2'b10; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_out_code !== {K285N, 10'b1010101010} || a_err_k !== 2'b10 || a_rd !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL illegal_k: got code=%b err=%b rd=%b, want code=%b err=10 rd=10",
               a_out_code, a_err_k, a_rd, {K285N, 10'b1010101010});
    end
    n_cmp++;
    if (c_out_code !== 10'b1010101010 || c_err_k !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL illegal_k_c: got code=%b err=%b, want code=1010101010 err=0", c_out_code, c_err_k);
    end
    in_data = 16'hB5B5; in_k = 2'b00;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_err_k !== 2'b00 || a_out_code !== {10'b1010101010, 10'b1010101010} || a_rd !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL illegal_k_clear: got code=%b err=%b rd=%b, want code=%b err=00 rd=10",
               a_out_code, a_err_k, a_rd, {10'b1010101010, 10'b1010101010});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] da, db;
    logic [1:0]  ka, kb;
    logic [23:0] ea, eb;
    do_reset();
    rand_beat(da, ka);
    rand_beat(db, kb);
    ea = ref_beat(da, ka, 2'b00);
    eb = ref_beat(db, kb, ea[21:20]);
    in_valid = 1'b1; in_data = da; in_k = ka; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = db; in_k = kb; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_code !== ea[19:0] || a_rd !== ea[21:20] ||
          a_err_k !== ea[23:22]) begin
        n_fail++;
        $display("[TB] FAIL stall cycle %0d: got rdy=%b v=%b code=%h rd=%b err=%b, want rdy=0 v=1 code=%h rd=%b err=%b",
                 i, a_in_ready, a_out_valid, a_out_code, a_rd, a_err_k, ea[19:0], ea[21:20], ea[23:22]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stall_release_ready: got %b, want 1", a_in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_out_code !== eb[19:0] || a_rd !== eb[21:20] || a_err_k !== eb[23:22]) begin
      n_fail++;
      $display("[TB] FAIL stall_release_beat: got v=%b code=%h rd=%b err=%b, want v=1 code=%h rd=%b err=%b",
               a_out_valid, a_out_code, a_rd, a_err_k, eb[19:0], eb[21:20], eb[23:22]);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_rd !== eb[21:20]) begin
      n_fail++;
      $display("[TB] FAIL stall_drain: got v=%b rd=%b, want v=0 rd=%b", a_out_valid, a_rd, eb[21:20]);
    end
  endtask

  task automatic test_random_stream(input int n, input int vprob, input int rprob);
    logic [23:0] q [$];
    logic [23:0] e;
    logic [1:0]  mrd;
    logic [15:0] d;
    logic [1:0]  k;
    logic        exp_ready;
    do_reset();
    mrd = 2'b00;
    for (int c = 0; c < n; c++) begin
      rand_beat(d, k);
      in_data = d; in_k = k;
      in_valid  = ($urandom_range(0, 99) < vprob);
      out_ready = ($urandom_range(0, 99) < rprob);
      #1;
      exp_ready = (q.size() == 0) || out_ready;
      n_cmp++;
      if (a_in_ready !== exp_ready || c_in_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL stream_ready cycle %0d: got %b/%b, want %b", c, a_in_ready, c_in_ready, exp_ready);
      end
      @(posedge clk);
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        e = ref_beat(d, k, mrd);
        mrd = e[21:20];
        q.push_back(e);
      end
      @(negedge clk);
      if (q.size() != 0) begin
        e = q[0];
        n_cmp++;
        if (a_out_valid !== 1'b1 || a_out_code !== e[19:0] || a_rd !== e[21:20] || a_err_k !== e[23:22] ||
            a_out_idle !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL stream_a cycle %0d: got v=%b code=%h rd=%b err=%b idle=%b, want v=1 code=%h rd=%b err=%b idle=0",
                   c, a_out_valid, a_out_code, a_rd, a_err_k, a_out_idle, e[19:0], e[21:20], e[23:22]);
        end
        n_cmp++;
        if (c_out_valid !== 1'b1 || c_out_code !== e[9:0] || c_rd !== e[20] || c_err_k !== e[22]) begin
          n_fail++;
          $display("[TB] FAIL stream_c cycle %0d: got v=%b code=%h rd=%b err=%b, want v=1 code=%h rd=%b err=%b",
                   c, c_out_valid, c_out_code, c_rd, c_err_k, e[9:0], e[20], e[22]);
        end
      end else begin
        n_cmp++;
        if (a_out_valid !== 1'b0 || c_out_valid !== 1'b0 || a_rd !== mrd) begin
          n_fail++;
          $display("[TB] FAIL stream_empty cycle %0d: got v=%b/%b rd=%b, want v=0/0 rd=%b",
                   c, a_out_valid, c_out_valid, a_rd, mrd);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_idle_directed();
    logic       sv [5];
    logic [9:0] sc [5];
    logic       sr [5];
    sv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    sc = '{K285N, K285P, K285N, 10'b1010101010, K285P};
    sr = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    n_cmp++;
    if (b_out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_before_edge: got v=%b, want 0", b_out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      b_in_valid = sv[i]; b_in_data = 16'hB5B5; b_in_k = 2'b00; b_out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (b_out_valid !== 1'b1 || b_out_idle !== !sv[i] || b_out_code !== {sc[i], sc[i]} ||
          b_rd !== {sr[i], sr[i]} || b_err_k !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL idle_directed beat %0d: got v=%b idle=%b code=%b rd=%b err=%b, want v=1 idle=%b code=%b rd=%b err=00",
                 i, b_out_valid, b_out_idle, b_out_code, b_rd, b_err_k, !sv[i], {sc[i], sc[i]}, {sr[i], sr[i]});
      end
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_idle_random(input int n, input int vprob, input int rprob);
    logic [23:0] held;
    logic        held_valid, held_idle, exp_ready;
    logic [1:0]  mrd;
    logic [15:0] d;
    logic [1:0]  k;
    do_reset();
    mrd = 2'b00; held = '0; held_valid = 1'b0; held_idle = 1'b0;
    for (int c = 0; c < n; c++) begin
      rand_beat(d, k);
      b_in_data = d; b_in_k = k;
      b_in_valid  = ($urandom_range(0, 99) < vprob);
      b_out_ready = ($urandom_range(0, 99) < rprob);
      #1;
      exp_ready = !held_valid || b_out_ready;
      n_cmp++;
      if (b_in_ready !== exp_ready) begin
        n_fail++;
        $display("[TB] FAIL idle_ready cycle %0d: got %b, want %b", c, b_in_ready, exp_ready);
      end
      @(posedge clk);
      if (exp_ready) begin
        held = b_in_valid ? ref_beat(d, k, mrd) : ref_beat(16'hBCBC, 2'b11, mrd);
        held_idle = !b_in_valid;
        held_valid = 1'b1;
        mrd = held[21:20];
      end
      @(negedge clk);
      n_cmp++;
      if (b_out_valid !== 1'b1 || b_out_idle !== held_idle || b_out_code !== held[19:0] ||
          b_rd !== held[21:20] || b_err_k !== held[23:22]) begin
        n_fail++;
        $display("[TB] FAIL idle_random cycle %0d: got v=%b idle=%b code=%h rd=%b err=%b, want v=1 idle=%b code=%h rd=%b err=%b",
                 c, b_out_valid, b_out_idle, b_out_code, b_rd, b_err_k, held_idle, held[19:0], held[21:20], held[23:22]);
      end
    end
    b_in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_data = 16'hBCBC; in_k = 2'b11; out_ready = 1'b1;
    b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    n_cmp++;
    if (a_out_valid !== 1'b1 || a_rd !== 2'b11 || b_out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL async_pre: got v=%b rd=%b bv=%b, want v=1 rd=11 bv=1", a_out_valid, a_rd, b_out_valid);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (a_out_valid !== 1'b0 || a_rd !== 2'b00 || a_out_code !== 20'd0 || b_out_valid !== 1'b0 ||
        b_rd !== 2'b00 || b_out_idle !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got v=%b rd=%b code=%h bv=%b brd=%b bidle=%b, want all 0",
               a_out_valid, a_rd, a_out_code, b_out_valid, b_rd, b_out_idle);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 16'hBCBC; in_k = 2'b11; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (a_out_code !== {K285N, K285N} || a_rd !== 2'b11 || b_out_code !== {K285N, K285N}) begin
      n_fail++;
      $display("[TB] FAIL async_restart: got code=%b rd=%b bcode=%b, want code=%b rd=11",
               a_out_code, a_rd, b_out_code, {K285N, K285N});
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_k = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_k = '0; b_out_ready = 1'b0;
    test_reset();
    test_directed();
    test_illegal_k();
    test_stall();
    test_random_stream(300, 70, 70);
    test_random_stream(300, 90, 30);
    test_random_stream(200, 30, 90);
    test_idle_directed();
    test_idle_random(400, 50, 60);
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
